dispatch_ctrl: RTL and testbench

Parametrised instruction dispatch controller. It is the successor to the fixed-width decoder in the microprocessor. It accepts one instruction per valid/ready handshake and classifies it by prefix opcode. It evaluates branch conditions against a configurable flag vector, then issues the instruction to exactly one unit (EU, BIU or FCU) and waits for that unit's completion. All outputs are driven; none are tri-stated. It adds a completion timeout and explicit error reporting, which the previous decoder lacked.

---
 rtl/dispatch_pkg.sv | 34 +++
 rtl/instr_classify.sv | 52 +++++
 rtl/dispatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_dispatch_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and encodings for the dispatch controller and its classifier.
package dispatch_pkg;

    typedef enum logic [2:0] {
        ARITH_I,
        MOV,
        L_ST,
        BRANCH,
        ARITH,
        COMP,
        ILLEGAL
    } instr_class_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_BUSY,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] SEL_EU_ARITH_I  = 2'b00;
    localparam logic [1:0] SEL_EU_ARITH    = 2'b01;
    localparam logic [1:0] SEL_EU_COMP     = 2'b10;
    localparam logic       SEL_BIU_MOV     = 1'b0;
    localparam logic       SEL_BIU_L_ST    = 1'b1;
    localparam logic       SEL_FCU_BRANCH  = 1'b0;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_OPCODE      = 2'b01;
    localparam logic [1:0] ERR_COND        = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT     = 2'b11;

endpackage

// File: rtl/instr_classify.sv
// Combinational opcode classification and branch-condition evaluation.
// fld is the captured instruction slice whose MSB is the opcode MSB; the
// condition field starts four bits below it.
module instr_classify
    import dispatch_pkg::*;
#(
    parameter int FLD_W  = 7,
    parameter int COND_W = 3,
    parameter int FLAG_W = 2
) (
    input  logic [FLD_W-1:0]  fld,
    input  logic [FLAG_W-1:0] flags,
    output instr_class_t      cls,
    output logic              cond_ok,
    output logic              cond_illegal
);

    logic [5:0]        opc;
    logic [COND_W-1:0] cond;
    logic              cond_match;

    assign opc  = fld[FLD_W-1 -: 6];
    assign cond = fld[FLD_W-5 -: COND_W];

    // Prefix decode: first matching prefix wins.
    always_comb begin
        cls = ILLEGAL;
        casez (opc)
            6'b0?????: cls = ARITH_I;
            6'b10????: cls = MOV;
            6'b110???: cls = L_ST;
            6'b1110??: cls = BRANCH;
            6'b11110?: cls = ARITH;
            6'b111110: cls = COMP;
            default:   cls = ILLEGAL;
        endcase
    end

    // Condition: 0 always taken; odd codes test flag set, even codes flag clear.
    always_comb begin
        cond_match = (cond == '0);
        for (int unsigned i = 0; i < FLAG_W; i++) begin
            if (cond == COND_W'(2 * i + 1)) cond_match = flags[i];
            if (cond == COND_W'(2 * i + 2)) cond_match = ~flags[i];
        end
    end

    // Condition results only matter for branches; other classes always proceed.
    assign cond_illegal = (cls == BRANCH) && (cond > COND_W'(2 * FLAG_W));
    assign cond_ok      = (cls != BRANCH) || (cond_match && !cond_illegal);

endmodule

// File: rtl/dispatch_ctrl.sv
// Instruction dispatch controller: accepts one instruction, classifies it,
// issues it to one execution unit and reports completion, skip or error.
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int IR_W    = 32,
    parameter int OPC_MSB = 21,
    parameter int COND_W  = 3,
    parameter int FLAG_W  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [IR_W-1:0]   ir,
    input  logic [FLAG_W-1:0] flags,
    output logic              cs_eu,
    output logic              cs_biu,
    output logic              cs_fcu,
    output logic [1:0]        sel_eu,
    output logic              sel_biu,
    output logic              sel_fcu,
    input  logic              ready_eu,
    input  logic              ready_biu,
    input  logic              ready_fcu,
    output logic              busy,
    output logic              done,
    output logic              taken,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int FLD_W   = (4 + COND_W > 6) ? 4 + COND_W : 6;
    localparam int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;

    state_t            state, state_nxt;
    logic [FLD_W-1:0]  fld_q;
    logic [FLAG_W-1:0] flags_q;
    logic [CNT_W-1:0]  cnt;
    instr_class_t      cls;
    logic              cond_ok;
    logic              cond_illegal;
    logic              unit_ready;
    logic              timeout_hit;
    logic              unused_ir;

    // Only the opcode/condition slice of ir is captured.
    assign unused_ir = ^ir;

    instr_classify #(
        .FLD_W  (FLD_W),
        .COND_W (COND_W),
        .FLAG_W (FLAG_W)
    ) u_classify (
        .fld          (fld_q),
        .flags        (flags_q),
        .cls          (cls),
        .cond_ok      (cond_ok),
        .cond_illegal (cond_illegal)
    );

    // State register plus instruction/flag capture on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            fld_q   <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && ir_valid) begin
                fld_q   <= ir[OPC_MSB -: FLD_W];
                flags_q <= flags;
            end
        end
    end

    // Busy-cycle counter: zero outside BUSY, saturating while in BUSY.
    always_ff @(posedge clk) begin
        if (rst || state != S_BUSY) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(TIMEOUT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_W'(TO_LAST));

    // Completion from the selected unit only.
    always_comb begin
        unit_ready = 1'b0;
        case (cls)
            ARITH_I, ARITH, COMP: unit_ready = ready_eu;
            MOV, L_ST:            unit_ready = ready_biu;
            BRANCH:               unit_ready = ready_fcu;
            default:              unit_ready = 1'b0;
        endcase
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_nxt = state;
        ir_ready  = 1'b0;
        busy      = 1'b1;
        cs_eu     = 1'b0;
        cs_biu    = 1'b0;
        cs_fcu    = 1'b0;
        sel_eu    = SEL_EU_ARITH_I;
        sel_biu   = SEL_BIU_MOV;
        sel_fcu   = SEL_FCU_BRANCH;
        done      = 1'b0;
        taken     = 1'b0;
        err       = 1'b0;
        err_code  = ERR_NONE;
        case (state)
            S_IDLE: begin
                ir_ready = 1'b1;
                busy     = 1'b0;
                if (ir_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (cls == ILLEGAL || cond_illegal) state_nxt = S_ERR;
                else if (!cond_ok)                  state_nxt = S_DONE;
                else                                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                case (cls)
                    ARITH_I: begin cs_eu  = 1'b1; sel_eu  = SEL_EU_ARITH_I; end
                    ARITH:   begin cs_eu  = 1'b1; sel_eu  = SEL_EU_ARITH;   end
                    COMP:    begin cs_eu  = 1'b1; sel_eu  = SEL_EU_COMP;    end
                    MOV:     begin cs_biu = 1'b1; sel_biu = SEL_BIU_MOV;    end
                    L_ST:    begin cs_biu = 1'b1; sel_biu = SEL_BIU_L_ST;   end
                    BRANCH:  begin cs_fcu = 1'b1; sel_fcu = SEL_FCU_BRANCH; end
                    default: ;
                endcase
                if (unit_ready)       state_nxt = S_DONE;
                else if (timeout_hit) state_nxt = S_ERR;
            end
            S_DONE: begin
                done      = 1'b1;
                // A branch reaching DONE with cond_ok set went through BUSY.
                taken     = (cls == BRANCH) && cond_ok;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                err = 1'b1;
                if (cls == ILLEGAL)   err_code = ERR_OPCODE;
                else if (cond_illegal) err_code = ERR_COND;
                else                   err_code = ERR_TIMEOUT;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed cases plus randomized
// instructions compared against a prefix-counting reference model.
module tb_dispatch_ctrl;

    localparam int IR_W = 32;
    localparam int TO   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ir_valid;
    logic              ir_ready;
    logic [IR_W-1:0]   ir;
    logic [1:0]        flags;
    logic              cs_eu, cs_biu, cs_fcu;
    logic [1:0]        sel_eu;
    logic              sel_biu, sel_fcu;
    logic              ready_eu, ready_biu, ready_fcu;
    logic              busy, done, taken, err;
    logic [1:0]        err_code;

    int checks = 0;
    int errors = 0;

    dispatch_ctrl #(
        .IR_W    (32),
        .OPC_MSB (21),
        .COND_W  (3),
        .FLAG_W  (2),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir        (ir),
        .flags     (flags),
        .cs_eu     (cs_eu),
        .cs_biu    (cs_biu),
        .cs_fcu    (cs_fcu),
        .sel_eu    (sel_eu),
        .sel_biu   (sel_biu),
        .sel_fcu   (sel_fcu),
        .ready_eu  (ready_eu),
        .ready_biu (ready_biu),
        .ready_fcu (ready_fcu),
        .busy      (busy),
        .done      (done),
        .taken     (taken),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count leading ones of the prefix to get the class; the
    // condition is decoded arithmetically from c.
    // unit: 1 EU, 2 BIU, 3 FCU; ecode: 0 none, 1 opcode, 2 condition.
    task automatic model(input logic [31:0] iw, input logic [1:0] fl,
                         output int unit, output int sel, output int ecode,
                         output bit untaken);
        logic [5:0] p;
        logic [2:0] c;
        int n;
        int k;
        p = iw[21:16];
        c = iw[17:15];
        n = 0;
        while (n < 6 && p[5 - n]) n++;
        unit = 0; sel = 0; ecode = 0; untaken = 0;
        case (n)
            0: begin unit = 1; sel = 0; end
            1: begin unit = 2; sel = 0; end
            2: begin unit = 2; sel = 1; end
            3: begin unit = 3; sel = 0; end
            4: begin unit = 1; sel = 1; end
            5: begin unit = 1; sel = 2; end
            default: ecode = 1;
        endcase
        if (n == 3) begin
            if (c > 4) ecode = 2;
            else if (c != 0) begin
                k = (int'(c) - 1) / 2;
                untaken = (fl[k] != c[0]);
            end
        end
    endtask

    task automatic check_idle_full(input string tag);
        check({tag, ".ir_ready"}, ir_ready, 1);
        check({tag, ".busy"},     busy, 0);
        check({tag, ".cs"},       {cs_eu, cs_biu, cs_fcu}, 0);
        check({tag, ".sel"},      {sel_eu, sel_biu, sel_fcu}, 0);
        check({tag, ".done"},     done, 0);
        check({tag, ".taken"},    taken, 0);
        check({tag, ".err"},      err, 0);
        check({tag, ".err_code"}, err_code, 0);
    endtask

    // One full transaction; ready_at is the BUSY cycle (1-based) in which the
    // selected unit raises ready, 0 meaning never.
    task automatic do_instr(input string tag, input logic [31:0] iw,
                            input logic [1:0] fl, input int ready_at);
        int unit, sel, ecode;
        bit untaken;
        bit fin;
        int j;
        logic [2:0] cs_exp;
        model(iw, fl, unit, sel, ecode, untaken);
        cs_exp = (unit == 1) ? 3'b100 : (unit == 2) ? 3'b010 : 3'b001;

        check({tag, ".accept_ready"}, ir_ready, 1);
        ir = iw; flags = fl; ir_valid = 1'b1;
        tick();
        // Post-accept noise that must have no effect.
        ir_valid  = 1'($urandom_range(0, 1));
        ir        = $urandom;
        flags     = 2'($urandom);
        ready_eu  = 1'($urandom_range(0, 1));
        ready_biu = 1'($urandom_range(0, 1));
        ready_fcu = 1'($urandom_range(0, 1));
        check({tag, ".dec_busy"},  busy, 1);
        check({tag, ".dec_ready"}, ir_ready, 0);
        check({tag, ".dec_cs"},    {cs_eu, cs_biu, cs_fcu}, 0);
        tick();
        if (ecode != 0) begin
            check({tag, ".err"},      err, 1);
            check({tag, ".err_code"}, err_code, 32'(ecode));
            check({tag, ".err_cs"},   {cs_eu, cs_biu, cs_fcu}, 0);
            check({tag, ".err_done"}, done, 0);
        end else if (untaken) begin
            check({tag, ".skip_done"},  done, 1);
            check({tag, ".skip_taken"}, taken, 0);
            check({tag, ".skip_cs"},    {cs_eu, cs_biu, cs_fcu}, 0);
            check({tag, ".skip_err"},   err, 0);
        end else begin
            j = 1;
            fin = 0;
            while (!fin) begin
                check({tag, ".busy_cs"},   {cs_eu, cs_biu, cs_fcu}, 32'(cs_exp));
                check({tag, ".busy_sel"},  (unit == 1) ? 32'(sel_eu) :
                                           (unit == 2) ? 32'(sel_biu) : 32'(sel_fcu),
                                           32'(sel));
                check({tag, ".busy_busy"}, busy, 1);
                check({tag, ".busy_done"}, done, 0);
                check({tag, ".busy_err"},  err, 0);
                ready_eu  = (unit == 1) ? (j == ready_at) : 1'($urandom_range(0, 1));
                ready_biu = (unit == 2) ? (j == ready_at) : 1'($urandom_range(0, 1));
                ready_fcu = (unit == 3) ? (j == ready_at) : 1'($urandom_range(0, 1));
                tick();
                if (j == ready_at) begin
                    check({tag, ".done"},    done, 1);
                    check({tag, ".taken"},   taken, (unit == 3) ? 1 : 0);
                    check({tag, ".done_err"}, err, 0);
                    check({tag, ".done_cs"}, {cs_eu, cs_biu, cs_fcu}, 0);
                    fin = 1;
                end else if (j == TO) begin
                    check({tag, ".to_err"},  err, 1);
                    check({tag, ".to_code"}, err_code, 3);
                    check({tag, ".to_done"}, done, 0);
                    check({tag, ".to_cs"},   {cs_eu, cs_biu, cs_fcu}, 0);
                    fin = 1;
                end
                j++;
            end
        end
        ir_valid = 1'b0;
        ready_eu = 1'b0; ready_biu = 1'b0; ready_fcu = 1'b0;
        tick();
        check({tag, ".ret_ready"}, ir_ready, 1);
        check({tag, ".ret_busy"},  busy, 0);
        check({tag, ".ret_done"},  done, 0);
        check({tag, ".ret_err"},   err, 0);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] p);
        logic [31:0] r;
        r = $urandom;
        r[21:16] = p;
        return r;
    endfunction

    function automatic logic [31:0] mk_br(input logic [2:0] c);
        logic [31:0] r;
        r = mk(6'b111000);
        r[17:15] = c;
        return r;
    endfunction

    initial begin
        logic [31:0] iw;
        logic [5:0]  p;
        int          n;

        rst = 1'b1; ir_valid = 1'b0; ir = '0; flags = '0;
        ready_eu = 1'b0; ready_biu = 1'b0; ready_fcu = 1'b0;
        tick();
        tick();
        check_idle_full("reset");
        rst = 1'b0;
        tick();
        check_idle_full("post_reset");

        do_instr("arith",      mk(6'b111100), 2'b00, 4);
        do_instr("l_st",       mk(6'b110101), 2'b11, 1);
        do_instr("mov",        mk(6'b101010), 2'b00, 2);
        do_instr("arith_i",    mk(6'b011111), 2'b10, 1);
        do_instr("comp",       mk(6'b111110), 2'b01, 3);
        do_instr("br_c1_f01",  mk_br(3'd1),   2'b01, 1);
        do_instr("br_c1_f00",  mk_br(3'd1),   2'b00, 1);
        do_instr("br_c4_f00",  mk_br(3'd4),   2'b00, 2);
        do_instr("br_c0",      mk_br(3'd0),   2'b11, 1);
        do_instr("illegal",    mk(6'b111111), 2'b00, 1);
        do_instr("br_c7",      mk_br(3'd7),   2'b11, 1);
        do_instr("br_c5",      mk_br(3'd5),   2'b01, 1);
        do_instr("timeout",    mk(6'b111100), 2'b00, 0);
        do_instr("ready_last", mk(6'b111100), 2'b00, TO);

        // Reset in the middle of BUSY.
        ir = mk(6'b111100); flags = 2'b00; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        tick();
        check("midrst.cs_eu", cs_eu, 1);
        tick();
        rst = 1'b1;
        tick();
        check_idle_full("midrst");
        rst = 1'b0;
        tick();
        check_idle_full("midrst_after");

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 6);
            p = 6'($urandom);
            for (int b = 0; b < n; b++) p[5 - b] = 1'b1;
            if (n < 6) p[5 - n] = 1'b0;
            iw = mk(p);
            do_instr($sformatf("rnd%0d", t), iw, 2'($urandom), $urandom_range(0, TO));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
